instruction_fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the instruction counter.
//  - Samples the 11-bit program address and issues reads to the synchronous instruction ROM (1-cycle read latency).
//  - Buffers returned words, each tagged with its PC, in a small FIFO.
//  - Hands words to decode over a valid/ready handshake.
//  - Raises fetch_stall to freeze the counter when full; discards all fetched state on a taken branch (flush).

---
 rtl/instruction_fetch_queue.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Fetch stage sitting between the instruction counter and decode. Each cycle
// it may issue a read of the synchronous instruction ROM (1-cycle latency) at
// the counter's current address. It tags the returned word with that address,
// buffers it in a small FIFO and presents the FIFO head to decode over a
// valid/ready handshake. It freezes the counter with fetch_stall when every
// slot is claimed. A taken branch (flush) discards all fetched state.
//
// Configuration macro:
//   IFQ_BYPASS_EN  when defined, a ROM word returning into an empty queue is
//                  presented to decode combinationally in the same cycle
//                  (latency N+1). When undefined, every word passes through
//                  the FIFO (latency N+2).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = reset)
//   pc_addr      in   current program address from the instruction counter
//   flush        in   taken branch/jump this cycle
//   fetch_stall  out  counter must hold pc_addr this cycle
//   imem_rd_en   out  ROM read strobe
//   imem_addr    out  ROM read address (= pc_addr)
//   imem_rdata   in   ROM data, valid the cycle after imem_rd_en
//   instr_out    out  instruction at queue head
//   instr_pc     out  address tag of instr_out
//   instr_valid  out  instr_out/instr_pc valid
//   instr_ready  in   decode accepts the head this cycle
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              fetch_stall,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so count + inflight can reach DEPTH without wrapping.
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_tag;
  entry_t             head_q;

  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               fifo_valid;
  logic               ret_valid;
  logic               bypass_take;
  logic               push;
  logic               pop;
  entry_t             ret_entry;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [PTR_W-1:0]   wr_ptr_n;
  logic [CNT_W-1:0]   count_n;

  // ---------------------------------------------------------------------------
  // Issue / stall. The inflight word already owns a slot, so it is counted
  // against capacity; a pop in the same cycle is not, which keeps the
  // occupancy path free of the decode-side ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    occupancy   = {1'b0, count} + (CNT_W + 1)'(inflight);
    issue       = reset && !flush && (occupancy < DEPTH_OCC);
    imem_rd_en  = issue;
    imem_addr   = pc_addr;
    fetch_stall = reset && !flush && !issue;
  end

  // ---------------------------------------------------------------------------
  // Return, push, pop and output selection.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_valid = (count != '0);
    ret_valid  = inflight && !flush;
    ret_entry  = '{data: imem_rdata, pc: inflight_tag};
`ifdef IFQ_BYPASS_EN
    bypass_take = ret_valid && !fifo_valid && instr_ready;
    if (ret_valid && !fifo_valid) begin
      instr_valid = 1'b1;
      instr_out   = imem_rdata;
      instr_pc    = inflight_tag;
    end else begin
      instr_valid = fifo_valid;
      instr_out   = head_q.data;
      instr_pc    = head_q.pc;
    end
`else
    bypass_take = 1'b0;
    instr_valid = fifo_valid;
    instr_out   = head_q.data;
    instr_pc    = head_q.pc;
`endif
    push     = ret_valid && !bypass_take;
    pop      = fifo_valid && instr_ready && !flush;
    rd_ptr_n = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_n = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_n  = count + CNT_W'(push) - CNT_W'(pop);
  end

  // ---------------------------------------------------------------------------
  // Control state. The head is kept in its own register so the output is
  // registered and holds its last value while the queue is empty.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the always_comb blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
      head_q       <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
      inflight <= issue;
      if (issue) inflight_tag <= pc_addr;
      // The new head is the word being written only when the queue would
      // otherwise be empty; a push can never land on a still-occupied head.
      if (count_n != '0) begin
        head_q <= (push && (wr_ptr == rd_ptr_n)) ? ret_entry : mem[rd_ptr_n];
      end
    end
  end

  // NOTE: the storage array has no reset; count and the pointers define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ret_entry;
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//
// Directed bench for instruction_fetch_queue. It models the instruction
// counter (holds on fetch_stall, loads the target on flush) and a synchronous
// ROM returning 0x1000 + address one cycle after the read strobe. Inputs are
// driven at the falling edge and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int FILL = 1;
`else
  localparam int FILL = 2;
`endif

  logic        clk;
  logic        reset;
  logic [10:0] pc_addr;
  logic        flush;
  logic        fetch_stall;
  logic        imem_rd_en;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [10:0] pc_q;

  instruction_fetch_queue #(.ADDR_W(11), .DATA_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: word = 0x1000 + address.
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'h1000 + 32'(imem_addr);
  end

  // One cycle: drive inputs at the falling edge, let them settle, then advance
  // the counter model from the stall seen this cycle.
  task automatic tick(input logic fl, input logic rdy, input logic [10:0] tgt);
    @(negedge clk);
    reset       = 1'b1;
    flush       = fl;
    instr_ready = rdy;
    pc_addr     = pc_q;
    #1;
    if (fl) pc_q = tgt;
    else if (!fetch_stall) pc_q = pc_q + 11'd1;
  endtask

  // Holds reset low across one rising edge; the next tick releases it.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_q = 11'd0; pc_addr = 11'd0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_q = 11'd0; pc_addr = 11'd0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (imem_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", imem_rd_en); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", fetch_stall); end
    tests_run++; if (instr_out !== 32'h0) begin tests_failed++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
    tests_run++; if (instr_pc !== 11'h0) begin tests_failed++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    tick(1'b0, 1'b0, 11'd0);
    tests_run++; if (imem_rd_en !== 1'b1) begin tests_failed++; $display("FAIL first_rd_en: got %b expected 1", imem_rd_en); end
    tests_run++; if (imem_addr !== 11'h0) begin tests_failed++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL first_valid: got %b expected 0", instr_valid); end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < FILL + 6; k++) begin
      tick(1'b0, 1'b1, 11'd0);
      if (k < FILL) begin
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_fill_valid[%0d]: got %b expected 0", k, instr_valid); end
      end else begin
        tests_run++;
        if (instr_valid !== 1'b1 || instr_out !== 32'h1000 + 32'(k - FILL) || instr_pc !== 11'(k - FILL)) begin
          tests_failed++;
          $display("FAIL stream_word[%0d]: got v=%b %h@%h expected v=1 %h@%h", k - FILL, instr_valid, instr_out, instr_pc, 32'h1000 + 32'(k - FILL), 11'(k - FILL));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (4) tick(1'b0, 1'b0, 11'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 11'd0);
      tests_run++;
      if (fetch_stall !== 1'b1 || imem_rd_en !== 1'b0 || imem_addr !== 11'd4 || instr_valid !== 1'b1 || instr_pc !== 11'd0) begin
        tests_failed++;
        $display("FAIL full_stall[%0d]: got stall=%b rd_en=%b addr=%h v=%b pc=%h expected stall=1 rd_en=0 addr=004 v=1 pc=000", k, fetch_stall, imem_rd_en, imem_addr, instr_valid, instr_pc);
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b1, 11'd0);
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 11'(k) || instr_out !== 32'h1000 + 32'(k)) begin
        tests_failed++;
        $display("FAIL drain[%0d]: got v=%b %h@%h expected v=1 %h@%h", k, instr_valid, instr_out, instr_pc, 32'h1000 + 32'(k), 11'(k));
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    repeat (4) tick(1'b0, 1'b0, 11'd0);  // three words queued, pc 3 in flight
    tick(1'b1, 1'b0, 11'h40);
    tests_run++;
    if (imem_rd_en !== 1'b0 || fetch_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_cycle: got rd_en=%b stall=%b expected rd_en=0 stall=0", imem_rd_en, fetch_stall);
    end
    tick(1'b0, 1'b1, 11'd0);
    tests_run++;
    if (instr_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 11'h40) begin
      tests_failed++;
      $display("FAIL post_flush: got v=%b rd_en=%b addr=%h expected v=0 rd_en=1 addr=040", instr_valid, imem_rd_en, imem_addr);
    end
    for (int m = 1; m <= FILL + 1; m++) begin
      tick(1'b0, 1'b1, 11'd0);
      if (m < FILL) begin
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_refill_valid: got %b expected 0", instr_valid); end
      end else begin
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 11'h40 + 11'(m - FILL) || instr_out !== 32'h1040 + 32'(m - FILL)) begin
          tests_failed++;
          $display("FAIL flush_target_word[%0d]: got v=%b %h@%h expected v=1 %h@%h", m - FILL, instr_valid, instr_out, instr_pc, 32'h1040 + 32'(m - FILL), 11'h40 + 11'(m - FILL));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int exp_idx;
    apply_reset();
    repeat (6) tick(1'b0, 1'b0, 11'd0);
    tests_run++;
    if (fetch_stall !== 1'b1 || instr_pc !== 11'd0) begin
      tests_failed++;
      $display("FAIL wrap_full: got stall=%b pc=%h expected stall=1 pc=000", fetch_stall, instr_pc);
    end
    exp_idx = 0;
    for (int k = 0; k < 24; k++) begin
      logic rdy;
      rdy = (k % 3) != 2;
      tick(1'b0, rdy, 11'd0);
      tests_run++;
      if (instr_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_valid[%0d]: got %b expected 1", k, instr_valid);
      end else if (rdy) begin
        tests_run++;
        if (instr_pc !== 11'(exp_idx) || instr_out !== 32'h1000 + 32'(exp_idx)) begin
          tests_failed++;
          $display("FAIL wrap_order[%0d]: got %h@%h expected %h@%h", exp_idx, instr_out, instr_pc, 32'h1000 + 32'(exp_idx), 11'(exp_idx));
        end
        exp_idx++;
      end
    end
    tests_run++;
    if (exp_idx < 10) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d words expected at least 10", exp_idx);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (5) tick(1'b0, 1'b0, 11'd0);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0 || fetch_stall !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 11'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b rd_en=%b stall=%b %h@%h expected all 0", instr_valid, imem_rd_en, fetch_stall, instr_out, instr_pc);
    end
    pc_q = 11'h20;
    tick(1'b0, 1'b1, 11'd0);
    tests_run++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 11'h20 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_issue: got rd_en=%b addr=%h v=%b expected rd_en=1 addr=020 v=0", imem_rd_en, imem_addr, instr_valid);
    end
    repeat (FILL) tick(1'b0, 1'b1, 11'd0);
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 11'h20 || instr_out !== 32'h1020) begin
      tests_failed++;
      $display("FAIL restart_word: got v=%b %h@%h expected v=1 00001020@020", instr_valid, instr_out, instr_pc);
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_addr = 11'd0; pc_q = 11'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
